// File: rtl/gpt_pkg.sv
// Shared definitions for the general-purpose timer channel logic.
//   GptCntWidth : default width of the time-base counter and compare values.
//   oc_mode_e   : output-compare mode encodings as presented on ocm_i.
package gpt_pkg;

  localparam int unsigned GptCntWidth = 32;

  typedef enum logic [2:0] {
    OcFrozen      = 3'b000,
    OcSetActive   = 3'b001,
    OcSetInactive = 3'b010,
    OcToggle      = 3'b011,
    OcForceLow    = 3'b100,
    OcForceHigh   = 3'b101,
    OcPwm1        = 3'b110,
    OcPwm2        = 3'b111
  } oc_mode_e;

endpackage

// File: rtl/gpt_ccr_preload.sv
// Shadow/active compare register pair.
//   clk_i     : clock
//   rst_ni    : synchronous active-low reset, clears both registers
//   wr_i      : write strobe qualifying data_i
//   data_i    : compare value written by software
//   preload_i : 1 = writes go to the shadow and reach the active copy on uev_i
//   uev_i     : update event from the time base
//   active_o  : compare value used for matching
module gpt_ccr_preload #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic [Width-1:0] data_i,
  input  logic             preload_i,
  input  logic             uev_i,
  output logic [Width-1:0] active_o
);

  logic [Width-1:0] shadow_q, shadow_d;
  logic [Width-1:0] active_q, active_d;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_i) begin
      shadow_d = data_i;
    end
    if (!preload_i) begin
      if (wr_i) begin
        active_d = data_i;
      end
    end else if (uev_i) begin
      // A write coinciding with the update bypasses the shadow.
      active_d = wr_i ? data_i : shadow_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/gpt_oc_channel.sv
// Output-compare channel of a general-purpose timer.
//   aclk_i/aresetn_i : clock, synchronous active-low reset
//   cnt_i, dir_i     : time-base counter value and direction (1 = down)
//   uev_i            : update event (preload transfer, clear-latch release)
//   ccr_i, ccr_wr_i  : compare value write; ocpe_i selects preloading
//   ocm_i            : output-compare mode
//   occe_i, etrf_i   : external clear enable and clear source
//   ccg_i            : software compare-event generation
//   ccp_i, cce_i     : pin polarity (1 = active-low) and pin enable
//   ocref_o          : registered reference waveform
//   oc_o             : pin output
//   ccif_o           : one-cycle compare-event pulse
//   ccr_act_o        : active compare value
module gpt_oc_channel
  import gpt_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = GptCntWidth
) (
  input  logic                 aclk_i,
  input  logic                 aresetn_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 dir_i,
  input  logic                 uev_i,
  input  logic [CNT_WIDTH-1:0] ccr_i,
  input  logic                 ccr_wr_i,
  input  logic                 ocpe_i,
  input  logic [2:0]           ocm_i,
  input  logic                 occe_i,
  input  logic                 etrf_i,
  input  logic                 ccg_i,
  input  logic                 ccp_i,
  input  logic                 cce_i,
  output logic                 ocref_o,
  output logic                 oc_o,
  output logic                 ccif_o,
  output logic [CNT_WIDTH-1:0] ccr_act_o
);

  logic [CNT_WIDTH-1:0] ccr_act;
  logic [CNT_WIDTH-1:0] prev_cnt_q;
  logic                 ocref_q, ocref_d;
  logic                 wave_q, wave_d;
  logic                 clr_q, clr_d;
  logic                 ccif_q, ccif_d;
  logic                 rst_seen_q;
  logic                 match;
  logic                 pwm1_lvl;
  oc_mode_e             mode;

  gpt_ccr_preload #(
    .Width(CNT_WIDTH)
  ) u_ccr_preload (
    .clk_i    (aclk_i),
    .rst_ni   (aresetn_i),
    .wr_i     (ccr_wr_i),
    .data_i   (ccr_i),
    .preload_i(ocpe_i),
    .uev_i    (uev_i),
    .active_o (ccr_act)
  );

  assign mode = oc_mode_e'(ocm_i);

  // Only a count that has just arrived at the compare value is an event, so a stalled
  // counter or a compare value moved onto the current count stays quiet.
  assign match = (cnt_i == ccr_act) && (cnt_i != prev_cnt_q);

  always_comb begin
    if (!dir_i) begin
      // All-ones compare means the output never deasserts while counting up.
      pwm1_lvl = (cnt_i < ccr_act) || (&ccr_act);
    end else begin
      pwm1_lvl = !(cnt_i > ccr_act);
    end
  end

  always_comb begin
    clr_d = clr_q;
    if (occe_i && etrf_i) begin
      clr_d = 1'b1;
    end else if (uev_i && !etrf_i) begin
      clr_d = 1'b0;
    end
  end

  // wave_q is the uncleared waveform; it is held while the clear latch is set so a
  // toggle sequence resumes where it left off.
  always_comb begin
    wave_d  = wave_q;
    ocref_d = 1'b0;
    if (!clr_d) begin
      unique case (mode)
        OcFrozen:      wave_d = ocref_q;
        OcSetActive:   wave_d = match ? 1'b1 : wave_q;
        OcSetInactive: wave_d = match ? 1'b0 : wave_q;
        OcToggle:      wave_d = match ? ~wave_q : wave_q;
        OcForceLow:    wave_d = 1'b0;
        OcForceHigh:   wave_d = 1'b1;
        OcPwm1:        wave_d = pwm1_lvl;
        OcPwm2:        wave_d = ~pwm1_lvl;
        default:       wave_d = wave_q;
      endcase
      ocref_d = wave_d;
    end
  end

  // Suppress events on the first edge after reset so reset never yields a pulse.
  assign ccif_d = (match || ccg_i) && !rst_seen_q;

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      prev_cnt_q <= '0;
      ocref_q    <= 1'b0;
      wave_q     <= 1'b0;
      clr_q      <= 1'b0;
      ccif_q     <= 1'b0;
      rst_seen_q <= 1'b1;
    end else begin
      prev_cnt_q <= cnt_i;
      ocref_q    <= ocref_d;
      wave_q     <= wave_d;
      clr_q      <= clr_d;
      ccif_q     <= ccif_d;
      rst_seen_q <= 1'b0;
    end
  end

  assign ocref_o   = ocref_q;
  assign oc_o      = cce_i & (ocref_q ^ ccp_i);
  assign ccif_o    = ccif_q;
  assign ccr_act_o = ccr_act;

endmodule
